// File: rtl/id_stage.sv
// id_stage: instruction decode with register file, opcode decoder, immediate sign-extension and branch resolution.
// Optional: define ID_RF_BYPASS_EN for write-through register-file reads from the WB port.
module id_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              branch_taken,
    output logic [31:0]       branch_address,
    output logic [31:0]       pc_out,
    output logic [3:0]        exe_cmd,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en_out,
    output logic [4:0]        dest,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] st_val
);

    typedef enum logic [5:0] {
        OP_NOP  = 6'b000000,
        OP_ADD  = 6'b000001,
        OP_SUB  = 6'b000011,
        OP_AND  = 6'b000101,
        OP_OR   = 6'b000110,
        OP_NOR  = 6'b000111,
        OP_XOR  = 6'b001000,
        OP_SLA  = 6'b001001,
        OP_SLL  = 6'b001010,
        OP_SRA  = 6'b001011,
        OP_SRL  = 6'b001100,
        OP_ADDI = 6'b100000,
        OP_SUBI = 6'b100001,
        OP_LD   = 6'b100100,
        OP_ST   = 6'b100101,
        OP_BEZ  = 6'b101000,
        OP_BNE  = 6'b101001,
        OP_JMP  = 6'b101010
    } opcode_e;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SHL = 4'b1000,
        CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010
    } exe_cmd_e;

    logic [5:0]        op;
    logic [4:0]        rs_idx;
    logic [4:0]        rt_idx;
    logic [4:0]        rd_idx;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [31:0]       br_offset;

    assign op       = instruction[31:26];
    assign rs_idx   = instruction[25:21];
    assign rt_idx   = instruction[20:16];
    assign rd_idx   = instruction[15:11];
    assign imm      = instruction[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign br_offset = {{14{imm[15]}}, imm, 2'b00};

    // Branch target is always computed; fetch only uses it when branch_taken is set.
    assign branch_address = pc_in + 32'd4 + br_offset;

    logic [DATA_W-1:0] rf_q [REG_CNT];
    logic [DATA_W-1:0] rf_d [REG_CNT];
    logic              wb_write;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign wb_write = wb_en && (wb_dest != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_write) begin
            rf_d[wb_dest] = wb_value;
        end
        rf_d[0] = '0;
    end

    always_comb begin
        rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
        rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];
`ifdef ID_RF_BYPASS_EN
        if (wb_write && (wb_dest == rs_idx)) begin
            rs_val = wb_value;
        end
        if (wb_write && (wb_dest == rt_idx)) begin
            rt_val = wb_value;
        end
`endif
    end

    logic [31:0]       pc_d,        pc_q;
    exe_cmd_e          exe_cmd_d,   exe_cmd_q;
    logic              mem_read_d,  mem_read_q;
    logic              mem_write_d, mem_write_q;
    logic              wb_en_d,     wb_en_q;
    logic [4:0]        dest_d,      dest_q;
    logic [DATA_W-1:0] val1_d,      val1_q;
    logic [DATA_W-1:0] val2_d,      val2_q;
    logic [DATA_W-1:0] st_val_d,    st_val_q;
    logic              is_rtype;
    logic              is_imm;

    always_comb begin
        pc_d         = pc_in;
        exe_cmd_d    = CMD_ADD;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        wb_en_d      = 1'b0;
        dest_d       = '0;
        val1_d       = '0;
        val2_d       = '0;
        st_val_d     = '0;
        branch_taken = 1'b0;
        is_rtype     = 1'b0;
        is_imm       = 1'b0;

        case (op)
            OP_ADD:  begin is_rtype = 1'b1; exe_cmd_d = CMD_ADD; end
            OP_SUB:  begin is_rtype = 1'b1; exe_cmd_d = CMD_SUB; end
            OP_AND:  begin is_rtype = 1'b1; exe_cmd_d = CMD_AND; end
            OP_OR:   begin is_rtype = 1'b1; exe_cmd_d = CMD_OR;  end
            OP_NOR:  begin is_rtype = 1'b1; exe_cmd_d = CMD_NOR; end
            OP_XOR:  begin is_rtype = 1'b1; exe_cmd_d = CMD_XOR; end
            OP_SLA:  begin is_rtype = 1'b1; exe_cmd_d = CMD_SHL; end
            OP_SLL:  begin is_rtype = 1'b1; exe_cmd_d = CMD_SHL; end
            OP_SRA:  begin is_rtype = 1'b1; exe_cmd_d = CMD_SRA; end
            OP_SRL:  begin is_rtype = 1'b1; exe_cmd_d = CMD_SRL; end
            OP_ADDI: begin is_imm = 1'b1; wb_en_d = 1'b1; exe_cmd_d = CMD_ADD; end
            OP_SUBI: begin is_imm = 1'b1; wb_en_d = 1'b1; exe_cmd_d = CMD_SUB; end
            OP_LD: begin
                is_imm     = 1'b1;
                wb_en_d    = 1'b1;
                mem_read_d = 1'b1;
            end
            OP_ST: begin
                is_imm      = 1'b1;
                mem_write_d = 1'b1;
                st_val_d    = rt_val;
            end
            OP_BEZ:  branch_taken = (rs_val == '0);
            OP_BNE:  branch_taken = (rs_val != rt_val);
            OP_JMP:  branch_taken = 1'b1;
            default: ;
        endcase

        if (is_rtype) begin
            wb_en_d = 1'b1;
            dest_d  = rd_idx;
            val1_d  = rs_val;
            val2_d  = rt_val;
        end
        if (is_imm) begin
            dest_d = rt_idx;
            val1_d = rs_val;
            val2_d = imm_sext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q        <= '{default: '0};
            pc_q        <= '0;
            exe_cmd_q   <= CMD_ADD;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            dest_q      <= '0;
            val1_q      <= '0;
            val2_q      <= '0;
            st_val_q    <= '0;
        end else begin
            rf_q        <= rf_d;
            pc_q        <= pc_d;
            exe_cmd_q   <= exe_cmd_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            wb_en_q     <= wb_en_d;
            dest_q      <= dest_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            st_val_q    <= st_val_d;
        end
    end

    assign pc_out    = pc_q;
    assign exe_cmd   = exe_cmd_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign wb_en_out = wb_en_q;
    assign dest      = dest_q;
    assign val1      = val1_q;
    assign val2      = val2_q;
    assign st_val    = st_val_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table followed by random stimulus against a behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] pc_out;
    logic [3:0]  exe_cmd;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en_out;
    logic [4:0]  dest;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;

    id_stage #(.DATA_W(32), .REG_CNT(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .pc_out(pc_out), .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
        .wb_en_out(wb_en_out), .dest(dest), .val1(val1), .val2(val2), .st_val(st_val)
    );

    typedef struct {
        bit        rst;
        bit [31:0] instr;
        bit [31:0] pc;
        bit        we;
        bit [4:0]  wd;
        bit [31:0] wv;
    } in_t;

    typedef struct {
        bit        chk_br;
        bit        taken;
        bit [31:0] baddr;
        bit [31:0] pc;
        bit        chk_cmd;
        bit [3:0]  cmd;
        bit        mr;
        bit        mw;
        bit        wb;
        bit        chk_dest;
        bit [4:0]  dest;
        bit        chk_v;
        bit [31:0] v1;
        bit [31:0] v2;
        bit        chk_st;
        bit [31:0] st;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t e;
    } vec_t;

    localparam int K_BUB = 0, K_R = 1, K_IMM = 2, K_LD = 3, K_ST = 4, K_BEZ = 5, K_BNE = 6, K_JMP = 7;

    int        total = 0;
    int        bad = 0;
    bit [31:0] mrf [32];
    int        kind_tab [64];
    bit [3:0]  cmd_tab [64];
    bit [5:0]  valid_ops [18];
    vec_t      vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] enc_r(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic bit [31:0] enc_i(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt, input bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic in_t mk_in(input bit r, input bit [31:0] ins, input bit [31:0] pc,
                                  input bit we, input bit [4:0] wd, input bit [31:0] wv);
        in_t i;
        i.rst = r; i.instr = ins; i.pc = pc; i.we = we; i.wd = wd; i.wv = wv;
        return i;
    endfunction

    function automatic exp_t ex_op(input bit [31:0] pc, input bit [3:0] cmd, input bit wb, input bit mr,
                                   input bit mw, input bit [4:0] d, input bit [31:0] v1, input bit [31:0] v2);
        exp_t e = '{default: 0};
        e.pc = pc; e.chk_cmd = 1; e.cmd = cmd; e.wb = wb; e.mr = mr; e.mw = mw;
        e.chk_dest = 1; e.dest = d; e.chk_v = 1; e.v1 = v1; e.v2 = v2;
        return e;
    endfunction

    function automatic exp_t ex_bub(input bit [31:0] pc);
        exp_t e = '{default: 0};
        e.pc = pc; e.chk_cmd = 1; e.chk_dest = 1;
        return e;
    endfunction

    function automatic exp_t ex_rst();
        exp_t e = '{default: 0};
        e.chk_cmd = 1; e.chk_dest = 1; e.chk_v = 1; e.chk_st = 1;
        return e;
    endfunction

    function automatic exp_t ex_br(input bit [31:0] pc, input bit t, input bit [31:0] ba);
        exp_t e = '{default: 0};
        e.pc = pc; e.chk_br = 1; e.taken = t; e.baddr = ba;
        return e;
    endfunction

    function automatic bit [31:0] mread(input bit [4:0] idx, input in_t i);
        if (idx == 0) return 32'd0;
`ifdef ID_RF_BYPASS_EN
        if (i.we && i.wd == idx) return i.wv;
`endif
        return mrf[idx];
    endfunction

    function automatic exp_t model(input in_t i);
        exp_t      e = '{default: 0};
        int        k;
        bit [31:0] a, b, simm;
        k    = kind_tab[i.instr[31:26]];
        a    = mread(i.instr[25:21], i);
        b    = mread(i.instr[20:16], i);
        simm = {{16{i.instr[15]}}, i.instr[15:0]};
        e.chk_br = 1;
        e.taken  = (k == K_JMP) || (k == K_BEZ && a == 0) || (k == K_BNE && a != b);
        e.baddr  = i.pc + 32'd4 + simm * 32'd4;
        if (i.rst) begin
            e.chk_cmd = 1; e.chk_dest = 1; e.chk_v = 1; e.chk_st = 1;
            return e;
        end
        e.pc       = i.pc;
        e.chk_cmd  = (k < K_BEZ);
        e.cmd      = cmd_tab[i.instr[31:26]];
        e.wb       = (k == K_R) || (k == K_IMM) || (k == K_LD);
        e.mr       = (k == K_LD);
        e.mw       = (k == K_ST);
        e.chk_dest = (k < K_BEZ);
        e.dest     = (k == K_R) ? i.instr[15:11] : (k == K_BUB) ? 5'd0 : i.instr[20:16];
        e.chk_v    = (k >= K_R) && (k <= K_ST);
        e.v1       = a;
        e.v2       = (k == K_R) ? b : simm;
        e.chk_st   = (k == K_ST);
        e.st       = b;
        return e;
    endfunction

    task automatic apply(input in_t i, input exp_t e);
        rst = i.rst; instruction = i.instr; pc_in = i.pc;
        wb_en = i.we; wb_dest = i.wd; wb_value = i.wv;
        #2;
        if (e.chk_br) begin
            chk("branch_taken", branch_taken, e.taken);
            chk("branch_address", branch_address, e.baddr);
        end
        @(posedge clk);
        if (i.rst) mrf = '{default: 0};
        else if (i.we && i.wd != 0) mrf[i.wd] = i.wv;
        #1;
        chk("pc_out", pc_out, e.pc);
        if (e.chk_cmd) chk("exe_cmd", exe_cmd, e.cmd);
        chk("mem_read", mem_read, e.mr);
        chk("mem_write", mem_write, e.mw);
        chk("wb_en_out", wb_en_out, e.wb);
        if (e.chk_dest) chk("dest", dest, e.dest);
        if (e.chk_v) begin
            chk("val1", val1, e.v1);
            chk("val2", val2, e.v2);
        end
        if (e.chk_st) chk("st_val", st_val, e.st);
    endtask

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.in = i; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t      e;
        in_t       i;
        bit [31:0] ins;
        bit [5:0]  op;

        for (int n = 0; n < 64; n++) begin kind_tab[n] = K_BUB; cmd_tab[n] = 4'b0000; end
        valid_ops = '{6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
                      6'b001010, 6'b001011, 6'b001100, 6'b100000, 6'b100001, 6'b100100, 6'b100101,
                      6'b101000, 6'b101001, 6'b101010, 6'b000000};
        kind_tab[6'b000001] = K_R; cmd_tab[6'b000001] = 4'b0000;
        kind_tab[6'b000011] = K_R; cmd_tab[6'b000011] = 4'b0010;
        kind_tab[6'b000101] = K_R; cmd_tab[6'b000101] = 4'b0100;
        kind_tab[6'b000110] = K_R; cmd_tab[6'b000110] = 4'b0101;
        kind_tab[6'b000111] = K_R; cmd_tab[6'b000111] = 4'b0110;
        kind_tab[6'b001000] = K_R; cmd_tab[6'b001000] = 4'b0111;
        kind_tab[6'b001001] = K_R; cmd_tab[6'b001001] = 4'b1000;
        kind_tab[6'b001010] = K_R; cmd_tab[6'b001010] = 4'b1000;
        kind_tab[6'b001011] = K_R; cmd_tab[6'b001011] = 4'b1001;
        kind_tab[6'b001100] = K_R; cmd_tab[6'b001100] = 4'b1010;
        kind_tab[6'b100000] = K_IMM; cmd_tab[6'b100000] = 4'b0000;
        kind_tab[6'b100001] = K_IMM; cmd_tab[6'b100001] = 4'b0010;
        kind_tab[6'b100100] = K_LD;
        kind_tab[6'b100101] = K_ST;
        kind_tab[6'b101000] = K_BEZ;
        kind_tab[6'b101001] = K_BNE;
        kind_tab[6'b101010] = K_JMP;

        // Directed vectors: inputs for one cycle plus the outputs they must produce.
        add(mk_in(1, enc_r(6'b000001, 5, 0, 6), 100, 1, 5, 7), ex_rst());
        add(mk_in(1, enc_r(6'b000001, 5, 0, 6), 100, 1, 5, 7), ex_rst());
        add(mk_in(0, enc_r(6'b000001, 5, 0, 6), 0, 0, 0, 0), ex_op(0, 4'b0000, 1, 0, 0, 6, 0, 0));
        e = ex_op(4, 4'b0000, 1, 0, 0, 1, 0, 1546); e.chk_br = 1; e.taken = 0; e.baddr = 6192;
        add(mk_in(0, enc_i(6'b100000, 0, 1, 16'd1546), 4, 0, 0, 0), e);
        add(mk_in(0, 32'd0, 8, 1, 3, 32'hFFFFF9F6), ex_bub(8));
        add(mk_in(0, 32'd0, 12, 1, 1, 3), ex_bub(12));
        e = ex_op(16, 4'b0000, 0, 0, 1, 3, 3, 4); e.chk_st = 1; e.st = 32'hFFFFF9F6;
        add(mk_in(0, enc_i(6'b100101, 1, 3, 16'd4), 16, 1, 2, 1), e);
        add(mk_in(0, enc_i(6'b101001, 1, 2, 16'hFFD6), 348, 0, 0, 0), ex_br(348, 1, 184));
        add(mk_in(0, 32'd0, 20, 1, 2, 3), ex_bub(20));
        add(mk_in(0, enc_i(6'b101001, 1, 2, 16'hFFD6), 348, 0, 0, 0), ex_br(348, 0, 184));
        add(mk_in(0, enc_i(6'b101000, 9, 0, 16'd2), 292, 0, 0, 0), ex_br(292, 1, 304));
        add(mk_in(0, enc_i(6'b101010, 0, 0, 16'hFFFF), 420, 0, 0, 0), ex_br(420, 1, 420));
`ifdef ID_RF_BYPASS_EN
        add(mk_in(0, enc_r(6'b001000, 7, 0, 8), 24, 1, 7, 522), ex_op(24, 4'b0111, 1, 0, 0, 8, 522, 0));
`else
        add(mk_in(0, enc_r(6'b001000, 7, 0, 8), 24, 1, 7, 522), ex_op(24, 4'b0111, 1, 0, 0, 8, 0, 0));
`endif
        add(mk_in(0, enc_r(6'b001000, 7, 0, 8), 28, 0, 0, 0), ex_op(28, 4'b0111, 1, 0, 0, 8, 522, 0));
        add(mk_in(0, enc_r(6'b000001, 0, 0, 10), 32, 1, 0, 99), ex_op(32, 4'b0000, 1, 0, 0, 10, 0, 0));
        add(mk_in(0, enc_r(6'b000001, 0, 0, 11), 36, 0, 0, 0), ex_op(36, 4'b0000, 1, 0, 0, 11, 0, 0));
        add(mk_in(0, enc_r(6'b111111, 1, 2, 3), 40, 0, 0, 0), ex_bub(40));
        add(mk_in(0, enc_i(6'b100100, 3, 4, 16'hFFF8), 44, 0, 0, 0),
            ex_op(44, 4'b0000, 1, 1, 0, 4, 32'hFFFFF9F6, 32'hFFFFFFF8));
        add(mk_in(0, enc_i(6'b100001, 1, 5, 16'd10), 48, 0, 0, 0), ex_op(48, 4'b0010, 1, 0, 0, 5, 3, 10));
        add(mk_in(0, enc_r(6'b001011, 1, 2, 9), 52, 0, 0, 0), ex_op(52, 4'b1001, 1, 0, 0, 9, 3, 3));
        add(mk_in(1, enc_i(6'b100000, 0, 1, 16'd5), 600, 1, 2, 55), ex_rst());
        add(mk_in(0, enc_r(6'b000001, 2, 1, 12), 604, 0, 0, 0), ex_op(604, 4'b0000, 1, 0, 0, 12, 0, 0));

        rst = 1; instruction = 0; pc_in = 0; wb_en = 0; wb_dest = 0; wb_value = 0;
        @(posedge clk);
        #1;
        foreach (vecs[n]) apply(vecs[n].in, vecs[n].e);

        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 9) < 8) ? valid_ops[$urandom_range(0, 17)] : 6'($urandom);
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
            i = mk_in($urandom_range(0, 49) == 0, ins, {$urandom} & 32'hFFFFFFFC,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom);
            apply(i, model(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
